// File: rtl/cnn_window_gen.sv
// Purpose: sliding KYxKX window generator for the convolution front end (line buffers + window regs).
// Latency: 1 clk from the pixel that completes a window to o_ot_valid.
// Backpressure: none; consumer is always ready, input gaps (i_in_valid=0) freeze all state.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   i_in_valid, i_in_pixel  raster-ordered pixel stream (col fastest), gaps allowed
//   o_ot_valid, o_ot_fmap   full window strobe; element (y,x) at [(y*KX+x)*I_F_BW +: I_F_BW],
//                           y=0 oldest row, x=0 oldest column
//   o_frame_done            pulses together with the last window of a frame
module cnn_window_gen #(
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int I_F_BW = 8,
    parameter int IW     = 28,
    parameter int IH     = 28
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_in_valid,
    input  logic [I_F_BW-1:0]          i_in_pixel,
    output logic                       o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]    o_ot_fmap,
    output logic                       o_frame_done
);

    localparam int CW = (IW > 1) ? $clog2(IW) : 1;
    localparam int RW = (IH > 1) ? $clog2(IH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
    localparam logic [CW-1:0] COL_EMIT = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);
    localparam logic [RW-1:0] ROW_EMIT = RW'(KY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              last_px;

    // Line buffer y holds the row that is (KY-1-y) rows above the current one.
    logic [I_F_BW-1:0] lb_q  [KY-1][IW];
    logic [I_F_BW-1:0] win_q [KY][KX];
    // Column entering the right edge of the window on an accepted pixel.
    logic [I_F_BW-1:0] col_new [KY];

    always_comb begin
        for (int y = 0; y < KY - 1; y++) begin
            col_new[y] = lb_q[y][col_q];
        end
        col_new[KY-1] = i_in_pixel;
    end

    // Counters, emit decision and frame FSM.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

        if (i_in_valid) begin
            // Windows never straddle a row: the first KX-1 columns only refill.
            valid_d = (row_q >= ROW_EMIT) && (col_q >= COL_EMIT);

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = last_px ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                S_IDLE: state_d = S_FILL;
                S_FILL: begin
                    if ((row_q == ROW_EMIT) && (col_q == '0)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_px) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int y = 0; y < KY; y++) begin
                for (int x = 0; x < KX; x++) begin
                    win_q[y][x] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (i_in_valid) begin
                for (int y = 0; y < KY; y++) begin
                    for (int x = 0; x < KX - 1; x++) begin
                        win_q[y][x] <= win_q[y][x+1];
                    end
                    win_q[y][KX-1] <= col_new[y];
                end
            end
        end
    end

    // Line-buffer storage is not reset: rows from a previous frame are only
    // read while row < KY-1, where the emit rule suppresses output anyway.
    always_ff @(posedge clk) begin
        if (reset_n && i_in_valid) begin
            for (int y = 0; y < KY - 2; y++) begin
                lb_q[y][col_q] <= lb_q[y+1][col_q];
            end
            lb_q[KY-2][col_q] <= i_in_pixel;
        end
    end

    always_comb begin
        o_ot_fmap = '0;
        for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX; x++) begin
                o_ot_fmap[(y*KX+x)*I_F_BW +: I_F_BW] = win_q[y][x];
            end
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Purpose: self-checking bench for cnn_window_gen (small 8x6 instance plus a default 28x28 instance).
// Latency: expectations are checked one clock after each driven input cycle.
// Backpressure: stimulus inserts input gaps; the design has no ready signal.
module tb_cnn_window_gen;

    localparam int KX = 5;
    localparam int KY = 5;
    localparam int FW = KX * KY * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          in_valid;
    logic [7:0]    in_pixel;
    logic          sel;
    logic          a_v, a_d, b_v, b_d;
    logic [FW-1:0] a_f, b_f;
    logic          obs_v, obs_d;
    logic [FW-1:0] obs_f;

    cnn_window_gen #(.KX(5), .KY(5), .I_F_BW(8), .IW(8), .IH(6)) u_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in_valid  (in_valid & ~sel),
        .i_in_pixel  (in_pixel),
        .o_ot_valid  (a_v),
        .o_ot_fmap   (a_f),
        .o_frame_done(a_d)
    );

    cnn_window_gen u_big (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in_valid  (in_valid & sel),
        .i_in_pixel  (in_pixel),
        .o_ot_valid  (b_v),
        .o_ot_fmap   (b_f),
        .o_frame_done(b_d)
    );

    assign obs_v = sel ? b_v : a_v;
    assign obs_d = sel ? b_d : a_d;
    assign obs_f = sel ? b_f : a_f;

    // Reference model: a picture of the frame so far, indexed by raster position.
    int            cur_iw, cur_ih, mk;
    logic [7:0]    img [28][28];
    logic          exp_v, exp_d;
    logic [FW-1:0] exp_f;

    int            checks, errors;
    int            n_valid, n_done, acc_cnt, first_px, stall_viol;
    logic [FW-1:0] caps[$];

    task automatic clear_stats();
        n_valid    = 0;
        n_done     = 0;
        acc_cnt    = 0;
        first_px   = -1;
        stall_viol = 0;
        caps.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] pix);
        int r, c;
        @(negedge clk);
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL valid: got %b expected %b (accepted=%0d)", obs_v, exp_v, acc_cnt);
        end
        checks++;
        if (obs_d !== exp_d) begin
            errors++;
            $display("FAIL frame_done: got %b expected %b (accepted=%0d)", obs_d, exp_d, acc_cnt);
        end
        if (exp_v) begin
            checks++;
            if (obs_f !== exp_f) begin
                errors++;
                $display("FAIL window: got %h expected %h", obs_f, exp_f);
            end
        end
        if (obs_v === 1'b1) begin
            n_valid++;
            caps.push_back(obs_f);
            if (first_px < 0) first_px = acc_cnt - 1;
            if (in_valid !== 1'b1) stall_viol++;
        end
        if (obs_d === 1'b1) n_done++;

        in_valid = v;
        in_pixel = pix;
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (v) begin
            r = mk / cur_iw;
            c = mk % cur_iw;
            img[r][c] = pix;
            if (r >= KY - 1 && c >= KX - 1) begin
                exp_v = 1'b1;
                for (int y = 0; y < KY; y++)
                    for (int x = 0; x < KX; x++)
                        exp_f[(y*KX+x)*8 +: 8] = img[r-KY+1+y][c-KX+1+x];
            end
            exp_d = (mk == cur_iw * cur_ih - 1);
            mk = (mk + 1) % (cur_iw * cur_ih);
            acc_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mk      = 0;
        exp_v   = 1'b0;
        exp_d   = 1'b0;
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        checks++;
        if (a_v !== 1'b0 || a_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_small_flags: valid=%b done=%b expected 0/0", a_v, a_d);
        end
        checks++;
        if (a_f !== '0) begin
            errors++;
            $display("FAIL reset_small_fmap: got %h expected 0", a_f);
        end
        checks++;
        if (b_v !== 1'b0 || b_d !== 1'b0 || b_f !== '0) begin
            errors++;
            $display("FAIL reset_big: valid=%b done=%b fmap=%h expected all 0", b_v, b_d, b_f);
        end
    endtask

    task automatic test_continuous();
        logic [FW-1:0] w;
        int bad;
        sel = 1'b0; cur_iw = 8; cur_ih = 6;
        clear_stats();
        for (int i = 0; i < 48; i++) step(1'b1, 8'(i));
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 8) begin errors++; $display("FAIL cont_count: got %0d expected 8", n_valid); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL cont_done: got %0d expected 1", n_done); end
        checks++;
        if (first_px != 36) begin errors++; $display("FAIL cont_first: got %0d expected 36", first_px); end
        checks++;
        if (caps.size() < 5) begin
            errors++;
            $display("FAIL cont_caps: got %0d windows expected at least 5", caps.size());
        end else begin
            w = caps[0];
            bad = 0;
            for (int y = 0; y < KY; y++)
                for (int x = 0; x < KX; x++)
                    if (w[(y*KX+x)*8 +: 8] !== 8'(y*8+x)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL cont_first_window: %0d bad elements expected 0", bad); end
            w = caps[3];
            checks++;
            if (w[(0*KX+4)*8 +: 8] !== 8'd7 || w[(4*KX+4)*8 +: 8] !== 8'd39) begin
                errors++;
                $display("FAIL row_end_window: got %0d,%0d expected 7,39",
                         w[(0*KX+4)*8 +: 8], w[(4*KX+4)*8 +: 8]);
            end
            w = caps[4];
            checks++;
            if (w[7:0] !== 8'd8) begin
                errors++;
                $display("FAIL row_wrap_window: got %0d expected 8", w[7:0]);
            end
        end
    endtask

    task automatic test_stall();
        int sent, cyc;
        sel = 1'b0; cur_iw = 8; cur_ih = 6;
        clear_stats();
        sent = 0; cyc = 0;
        while (sent < 48) begin
            if (cyc % 3 == 0) begin
                step(1'b1, 8'(sent));
                sent++;
            end else begin
                step(1'b0, 8'hAA);
            end
            cyc++;
        end
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", n_valid); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", n_done); end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_valid_after_gap: got %0d occurrences expected 0", stall_viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] w;
        int bad;
        sel = 1'b0; cur_iw = 8; cur_ih = 6;
        clear_stats();
        for (int i = 0; i < 48; i++) step(1'b1, 8'(i));
        for (int i = 0; i < 48; i++) step(1'b1, 8'(i + 100));
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", n_valid); end
        checks++;
        if (n_done != 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", n_done); end
        bad = 0;
        for (int k = 8; k < caps.size(); k++) begin
            w = caps[k];
            for (int e = 0; e < KX * KY; e++)
                if (w[e*8 +: 8] < 8'd100) bad++;
        end
        checks++;
        if (bad != 0 || caps.size() != 16) begin
            errors++;
            $display("FAIL b2b_stale: %0d stale elements in %0d windows expected 0 in 16", bad, caps.size());
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; cur_iw = 8; cur_ih = 6;
        clear_stats();
        for (int i = 0; i <= 30; i++) step(1'b1, 8'(i));
        do_reset();
        checks++;
        if (a_v !== 1'b0 || a_d !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: valid=%b done=%b expected 0/0", a_v, a_d);
        end
        for (int i = 0; i < 48; i++) step(1'b1, 8'(i));
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 8) begin errors++; $display("FAIL midreset_count: got %0d expected 8", n_valid); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL midreset_done: got %0d expected 1", n_done); end
        checks++;
        if (first_px != 36) begin errors++; $display("FAIL midreset_first: got %0d expected 36", first_px); end
    endtask

    task automatic test_random();
        int sent;
        sel = 1'b0; cur_iw = 8; cur_ih = 6;
        clear_stats();
        sent = 0;
        while (sent < 3 * 48) begin
            if ($urandom_range(0, 9) < 6) begin
                step(1'b1, 8'($urandom));
                sent++;
            end else begin
                step(1'b0, 8'($urandom));
            end
        end
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 24) begin errors++; $display("FAIL rand_count: got %0d expected 24", n_valid); end
        checks++;
        if (n_done != 3) begin errors++; $display("FAIL rand_done: got %0d expected 3", n_done); end
    endtask

    task automatic test_defaults();
        logic [FW-1:0] w;
        sel = 1'b1; cur_iw = 28; cur_ih = 28; mk = 0;
        clear_stats();
        for (int i = 0; i < 784; i++) step(1'b1, 8'(i % 256));
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (n_valid != 576) begin errors++; $display("FAIL dflt_count: got %0d expected 576", n_valid); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL dflt_done: got %0d expected 1", n_done); end
        checks++;
        if (first_px != 116) begin errors++; $display("FAIL dflt_first: got %0d expected 116", first_px); end
        checks++;
        if (caps.size() == 0) begin
            errors++;
            $display("FAIL dflt_elem00: got no window expected value 0");
        end else begin
            w = caps[0];
            if (w[7:0] !== 8'd0) begin
                errors++;
                $display("FAIL dflt_elem00: got %0d expected 0", w[7:0]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        sel      = 1'b0;
        cur_iw   = 8;
        cur_ih   = 6;
        mk       = 0;
        exp_v    = 1'b0;
        exp_d    = 1'b0;
        exp_f    = '0;
        clear_stats();

        test_reset();
        test_continuous();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_defaults();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
